// File: rtl/sio_frame_ctrl_pkg.sv
// ============================================================================
//  Module      : sio_frame_ctrl_pkg
//  Description : State encoding, status codes, SIO reply bytes and checksum step
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sio_frame_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_TX_RD    = 4'd1,
        S_TX_PUT   = 4'd2,
        S_TX_WAIT  = 4'd3,
        S_TX_CSUM  = 4'd4,
        S_TX_CWAIT = 4'd5,
        S_TX_DRAIN = 4'd6,
        S_RX_ACK   = 4'd7,
        S_RX_CMPL  = 4'd8,
        S_RX_DATA  = 4'd9,
        S_RX_CSUM  = 4'd10,
        S_FIN      = 4'd11
    } sio_state_e;

    localparam logic [2:0] STAT_OK      = 3'd0;
    localparam logic [2:0] STAT_NAK     = 3'd1;
    localparam logic [2:0] STAT_FRAMERR = 3'd2;
    localparam logic [2:0] STAT_CSUM    = 3'd3;
    localparam logic [2:0] STAT_TIMEOUT = 3'd4;
    localparam logic [2:0] STAT_BADLEN  = 3'd5;

    localparam logic [7:0] SIO_ACK  = 8'h41;
    localparam logic [7:0] SIO_CMPL = 8'h43;

    // Carry out of bit 7 is folded back into bit 0 (0xFF + 0x01 -> 0x01).
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, acc} + {1'b0, b};
        return s[7:0] + {7'd0, s[8]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sio_frame_ctrl_csum.sv
// ============================================================================
//  Module      : sio_frame_ctrl_csum
//  Description : End-around-carry checksum accumulator for SIO frames
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sio_frame_ctrl_csum
    import sio_frame_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enp,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] data,
    output logic [7:0] csum
);

    logic [7:0] csum_q;
    logic [7:0] csum_d;

    always_comb begin
        csum_d = csum_q;
        if (enp) begin
            if (clr) begin
                csum_d = 8'h00;
            end else if (add) begin
                csum_d = csum_step(csum_q, data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;

endmodule

`default_nettype wire

// File: rtl/sio_frame_ctrl.sv
// ============================================================================
//  Module      : sio_frame_ctrl
//  Description : Sequences one half-duplex SIO command/reply transaction on SER_core
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sio_frame_ctrl
    import sio_frame_ctrl_pkg::*;
#(
    parameter int          BUF_DEPTH = 128,
    parameter int          ADDR_W    = 7,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enp,
    input  logic              bufWr,
    input  logic [ADDR_W-1:0] bufAddr,
    input  logic [7:0]        bufWData,
    output logic [7:0]        bufRData,
    input  logic [7:0]        txLen,
    input  logic [7:0]        rxLen,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2:0]        status,
    output logic [7:0]        serDw,
    output logic              serAddrDw,
    input  logic              sdoCompl,
    input  logic              sdoFinish,
    input  logic              sdiCompl,
    input  logic              framerr,
    input  logic [7:0]        serDr
);

    localparam logic [8:0] C_DEPTH = 9'(BUF_DEPTH);

    sio_state_e        state_q, state_d;
    logic [8:0]        idx_q, idx_d;
    logic [15:0]       timer_q, timer_d;
    logic [2:0]        status_q, status_d;
    logic              busy_q, busy_d;
    logic [7:0]        ser_dw_q, ser_dw_d;
    logic [7:0]        buf_rdata_q, buf_rdata_d;

    logic [7:0]        mem [BUF_DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    logic              csum_clr;
    logic              csum_add;
    logic [7:0]        csum_byte;
    logic [7:0]        csum;
    logic              len_bad;

    assign len_bad = (txLen == 8'd0) || ({1'b0, txLen} > C_DEPTH) || ({1'b0, rxLen} > C_DEPTH);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        status_d    = status_q;
        busy_d      = busy_q;
        ser_dw_d    = ser_dw_q;
        buf_rdata_d = buf_rdata_q;
        mem_we      = 1'b0;
        mem_waddr   = bufAddr;
        mem_wdata   = bufWData;
        csum_clr    = 1'b0;
        csum_add    = 1'b0;
        csum_byte   = ser_dw_q;

        if (enp) begin
            buf_rdata_d = mem[bufAddr];
            mem_we      = bufWr && !busy_q;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len_bad) begin
                            status_d = STAT_BADLEN;
                            state_d  = S_FIN;
                        end else begin
                            status_d = STAT_OK;
                            busy_d   = 1'b1;
                            idx_d    = 9'd0;
                            csum_clr = 1'b1;
                            state_d  = S_TX_RD;
                        end
                    end
                end
                S_TX_RD: begin
                    ser_dw_d = mem[idx_q[ADDR_W-1:0]];
                    state_d  = S_TX_PUT;
                end
                S_TX_PUT: begin
                    csum_add = 1'b1;
                    idx_d    = idx_q + 9'd1;
                    state_d  = S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (sdoCompl) begin
                        if (idx_q < {1'b0, txLen}) begin
                            state_d = S_TX_RD;
                        end else begin
                            ser_dw_d = csum;
                            state_d  = S_TX_CSUM;
                        end
                    end
                end
                S_TX_CSUM: state_d = S_TX_CWAIT;
                S_TX_CWAIT: begin
                    if (sdoCompl) state_d = S_TX_DRAIN;
                end
                S_TX_DRAIN: begin
                    if (sdoFinish) begin
                        timer_d = 16'd0;
                        state_d = S_RX_ACK;
                    end
                end
                S_RX_ACK, S_RX_CMPL, S_RX_DATA, S_RX_CSUM: begin
                    // A framing error wins over a byte completing in the same tick.
                    if (framerr) begin
                        status_d = STAT_FRAMERR;
                        state_d  = S_FIN;
                    end else if (sdiCompl) begin
                        timer_d = 16'd0;
                        case (state_q)
                            S_RX_ACK: begin
                                if (serDr == SIO_ACK) begin
                                    state_d = S_RX_CMPL;
                                end else begin
                                    status_d = STAT_NAK;
                                    state_d  = S_FIN;
                                end
                            end
                            S_RX_CMPL: begin
                                if (serDr != SIO_CMPL) begin
                                    status_d = STAT_NAK;
                                    state_d  = S_FIN;
                                end else if (rxLen == 8'd0) begin
                                    state_d = S_FIN;
                                end else begin
                                    csum_clr = 1'b1;
                                    idx_d    = 9'd0;
                                    state_d  = S_RX_DATA;
                                end
                            end
                            S_RX_DATA: begin
                                mem_we    = 1'b1;
                                mem_waddr = idx_q[ADDR_W-1:0];
                                mem_wdata = serDr;
                                csum_add  = 1'b1;
                                csum_byte = serDr;
                                idx_d     = idx_q + 9'd1;
                                if (idx_d == {1'b0, rxLen}) state_d = S_RX_CSUM;
                            end
                            default: begin
                                status_d = (serDr == csum) ? STAT_OK : STAT_CSUM;
                                state_d  = S_FIN;
                            end
                        endcase
                    end else begin
                        timer_d = timer_q + 16'd1;
                        if (timer_d == TIMEOUT) begin
                            status_d = STAT_TIMEOUT;
                            state_d  = S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 9'd0;
            timer_q     <= 16'd0;
            status_q    <= STAT_OK;
            busy_q      <= 1'b0;
            ser_dw_q    <= 8'h00;
            buf_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            status_q    <= status_d;
            busy_q      <= busy_d;
            ser_dw_q    <= ser_dw_d;
            buf_rdata_q <= buf_rdata_d;
        end
    end

    // Buffer contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    sio_frame_ctrl_csum u_csum (
        .clk   (clk),
        .reset (reset),
        .enp   (enp),
        .clr   (csum_clr),
        .add   (csum_add),
        .data  (csum_byte),
        .csum  (csum)
    );

    assign bufRData  = buf_rdata_q;
    assign busy      = busy_q;
    assign done      = (state_q == S_FIN);
    assign status    = status_q;
    assign serDw     = ser_dw_q;
    assign serAddrDw = (state_q == S_TX_PUT) || (state_q == S_TX_CSUM);

endmodule

`default_nettype wire

// File: tb/tb_sio_frame_ctrl.sv
// ============================================================================
//  Module      : tb_sio_frame_ctrl
//  Description : Directed vector bench for sio_frame_ctrl with a small SER_core model
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sio_frame_ctrl;

    localparam logic [15:0] C_TO = 16'd200;

    logic       clk;
    logic       reset;
    logic       enp;
    logic       bufWr;
    logic [6:0] bufAddr;
    logic [7:0] bufWData;
    logic [7:0] bufRData;
    logic [7:0] txLen;
    logic [7:0] rxLen;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] status;
    logic [7:0] serDw;
    logic       serAddrDw;
    logic       sdoCompl;
    logic       sdoFinish;
    logic       sdiCompl;
    logic       framerr;
    logic [7:0] serDr;

    sio_frame_ctrl #(.BUF_DEPTH(128), .ADDR_W(7), .TIMEOUT(C_TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .enp       (enp),
        .bufWr     (bufWr),
        .bufAddr   (bufAddr),
        .bufWData  (bufWData),
        .bufRData  (bufRData),
        .txLen     (txLen),
        .rxLen     (rxLen),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .serDw     (serDw),
        .serAddrDw (serAddrDw),
        .sdoCompl  (sdoCompl),
        .sdoFinish (sdoFinish),
        .sdiCompl  (sdiCompl),
        .framerr   (framerr),
        .serDr     (serDr)
    );

    typedef struct {
        int         tx_len;
        int         rx_len;
        logic [7:0] tx [4];
        int         nrep;
        logic [8:0] rep [5];   // bit 8 set = framing error pulse instead of a byte
        int         exp_status;
        int         exp_strobes;
        logic [7:0] exp_csum;
        logic [7:0] exp_b0;
        logic [7:0] exp_b1;
    } vec_t;

    vec_t       vt [11];
    logic [7:0] cap_q [$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         fin_cyc = 0;
    int         done_cyc = 0;
    int         done_cnt = 0;
    logic       seen_done = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SER_core stand-in: holding reg empties 2 ticks after a write, line idles 6 ticks after the last.
    initial begin
        int ccnt;
        int fcnt;
        ccnt = 0;
        fcnt = 0;
        sdoCompl = 1'b0;
        sdoFinish = 1'b1;
        forever begin
            @(negedge clk);
            sdoCompl = 1'b0;
            if (serAddrDw === 1'b1) begin
                cap_q.push_back(serDw);
                ccnt = 2;
                fcnt = 6;
                sdoFinish = 1'b0;
            end else begin
                if (ccnt > 0) begin
                    ccnt--;
                    if (ccnt == 0) sdoCompl = 1'b1;
                end
                if (fcnt > 0) begin
                    fcnt--;
                    if (fcnt == 0) begin
                        sdoFinish = 1'b1;
                        fin_cyc = cyc;
                    end
                end
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (done === 1'b1 && !seen_done) begin
            seen_done = 1'b1;
            done_cyc = cyc;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        tick();
        bufAddr = 7'(a);
        bufWData = d;
        bufWr = 1'b1;
        tick();
        bufWr = 1'b0;
    endtask

    task automatic host_read(input int a, output logic [7:0] d);
        tick();
        bufAddr = 7'(a);
        tick();
        d = bufRData;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int         guard;
        int         d0;
        logic [7:0] b;
        logic [7:0] last;
        string      tag;
        tag = $sformatf("v%0d", k);
        for (int i = 0; i < 4; i++)
            if (v.tx_len <= 4 && i < v.tx_len) host_write(i, v.tx[i]);
        tick();
        cap_q.delete();
        seen_done = 1'b0;
        d0 = done_cnt;
        txLen = 8'(v.tx_len);
        rxLen = 8'(v.rx_len);
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!seen_done && !(v.exp_strobes > 0 && cap_q.size() == v.exp_strobes && sdoFinish) && guard < 400) begin
            tick();
            guard++;
        end
        check({tag, "_tx_bound"}, int'(guard < 400), 1);
        tick();
        tick();
        for (int j = 0; j < v.nrep; j++) begin
            if (seen_done) break;
            if (v.rep[j][8]) framerr = 1'b1;
            else begin
                serDr = v.rep[j][7:0];
                sdiCompl = 1'b1;
            end
            tick();
            sdiCompl = 1'b0;
            framerr = 1'b0;
            tick();
        end
        guard = 0;
        while (!seen_done && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        tick();
        last = (cap_q.size() > 0) ? cap_q[cap_q.size()-1] : 8'h00;
        check({tag, "_status"}, int'(status), v.exp_status);
        check({tag, "_strobes"}, cap_q.size(), v.exp_strobes);
        check({tag, "_csum_byte"}, int'(last), int'(v.exp_csum));
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_busy"}, int'(busy), 0);
        for (int i = 0; i < v.exp_strobes - 1; i++) begin
            b = (i < cap_q.size()) ? cap_q[i] : 8'h00;
            check($sformatf("%s_txbyte%0d", tag, i), int'(b), int'(v.tx[i]));
        end
        host_read(0, b);
        check({tag, "_buf0"}, int'(b), int'(v.exp_b0));
        host_read(1, b);
        check({tag, "_buf1"}, int'(b), int'(v.exp_b1));
    endtask

    initial begin
        int         guard;
        int         ncap;
        logic [7:0] b;
        reset = 1'b1;
        enp = 1'b1;
        bufWr = 1'b0;
        bufAddr = 7'd0;
        bufWData = 8'h00;
        txLen = 8'd0;
        rxLen = 8'd0;
        start = 1'b0;
        sdiCompl = 1'b0;
        framerr = 1'b0;
        serDr = 8'h00;
        repeat (3) @(posedge clk);
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addrdw", int'(serAddrDw), 0);
        check("rst_serdw", int'(serDw), 0);
        check("rst_status", int'(status), 0);
        check("rst_rdata", int'(bufRData), 0);
        reset = 1'b0;

        vt[0]  = '{4, 0, '{8'h31, 8'h52, 8'h01, 8'h00}, 2, '{9'h041, 9'h043, 9'h0, 9'h0, 9'h0}, 0, 5, 8'h84, 8'h31, 8'h52};
        vt[1]  = '{2, 0, '{8'hFF, 8'h01, 8'h00, 8'h00}, 2, '{9'h041, 9'h043, 9'h0, 9'h0, 9'h0}, 0, 3, 8'h01, 8'hFF, 8'h01};
        vt[2]  = '{2, 0, '{8'h80, 8'h80, 8'h00, 8'h00}, 2, '{9'h041, 9'h043, 9'h0, 9'h0, 9'h0}, 0, 3, 8'h01, 8'h80, 8'h80};
        vt[3]  = '{4, 2, '{8'h31, 8'h52, 8'h01, 8'h00}, 5, '{9'h041, 9'h043, 9'h010, 9'h020, 9'h030}, 0, 5, 8'h84, 8'h10, 8'h20};
        vt[4]  = '{4, 2, '{8'h31, 8'h52, 8'h01, 8'h00}, 5, '{9'h041, 9'h043, 9'h010, 9'h020, 9'h031}, 3, 5, 8'h84, 8'h10, 8'h20};
        vt[5]  = '{2, 2, '{8'h55, 8'h66, 8'h00, 8'h00}, 1, '{9'h04E, 9'h0, 9'h0, 9'h0, 9'h0}, 1, 3, 8'hBB, 8'h55, 8'h66};
        vt[6]  = '{2, 0, '{8'h55, 8'h66, 8'h00, 8'h00}, 2, '{9'h041, 9'h042, 9'h0, 9'h0, 9'h0}, 1, 3, 8'hBB, 8'h55, 8'h66};
        vt[7]  = '{2, 2, '{8'h12, 8'h34, 8'h00, 8'h00}, 4, '{9'h041, 9'h043, 9'h077, 9'h100, 9'h0}, 2, 3, 8'h46, 8'h77, 8'h34};
        vt[8]  = '{0, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, '{9'h0, 9'h0, 9'h0, 9'h0, 9'h0}, 5, 0, 8'h00, 8'h77, 8'h34};
        vt[9]  = '{200, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, '{9'h0, 9'h0, 9'h0, 9'h0, 9'h0}, 5, 0, 8'h00, 8'h77, 8'h34};
        vt[10] = '{1, 129, '{8'hA5, 8'h00, 8'h00, 8'h00}, 0, '{9'h0, 9'h0, 9'h0, 9'h0, 9'h0}, 5, 0, 8'h00, 8'hA5, 8'h34};

        for (int k = 0; k < 11; k++) run_vec(k, vt[k]);

        // No reply after the frame: abort exactly C_TO ticks after entering RX_ACK.
        host_write(0, 8'hAA);
        tick();
        cap_q.delete();
        seen_done = 1'b0;
        txLen = 8'd1;
        rxLen = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!seen_done && guard < 1000) begin
            tick();
            guard++;
        end
        check("to_bound", int'(seen_done), 1);
        check("to_status", int'(status), 4);
        check("to_latency", done_cyc - fin_cyc, int'(C_TO) + 1);
        check("to_strobes", cap_q.size(), 2);

        // start while enp is low must not launch a transaction.
        tick();
        seen_done = 1'b0;
        enp = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        enp = 1'b1;
        repeat (2) tick();
        check("enp_busy", int'(busy), 0);
        check("enp_done", int'(seen_done), 0);

        // Reset while the first byte waits in TX_WAIT.
        for (int i = 0; i < 4; i++) host_write(i, 8'h11 * 8'(i + 1));
        tick();
        cap_q.delete();
        seen_done = 1'b0;
        txLen = 8'd4;
        rxLen = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (cap_q.size() < 1 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        check("rst_mid_busy_pre", int'(busy), 1);
        reset = 1'b1;
        tick();
        check("rst_mid_busy", int'(busy), 0);
        reset = 1'b0;
        ncap = cap_q.size();
        repeat (30) tick();
        check("rst_mid_strobes", cap_q.size(), ncap);
        check("rst_mid_strobes1", ncap, 1);
        check("rst_mid_done", int'(seen_done), 0);
        check("rst_mid_status", int'(status), 0);
        host_read(2, b);
        check("rst_mid_buf_kept", int'(b), 8'h33);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
